match_controller: RTL and testbench
===================================

# match_controller

Sequences a Pong match on top of the game datapath. It gates per-frame advancement of the game logic, issues serves, and keeps the score. It sits between the graphics frame timing, the game logic and the board inputs, in the `clk_vga` domain. It turns the game logic's free-running play into a start → serve → play → point → game-over flow, and exports scores and the winner for the seven-segment and LED displays.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win; range 1–15.
- `SERVE_DELAY`, 60: frames between entering SERVE and the serve pulse; must be ≥1.
- `POINT_HOLD`, 90: frames the field stays frozen after a point; must be ≥1.

Ports:
- `clk`, in, 1: pixel clock; the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per frame, at vsync start.
- `miss_left`, in, 1: one-cycle pulse; the ball passed the left pad.
- `miss_right`, in, 1: one-cycle pulse; the ball passed the right pad.
- `start`, in, 1: level, active-high, already debounced.
- `pause`, in, 1: level, active-high.
- `random`, in, 8: pseudorandom byte.
- `step`, out, 1: one-cycle pulse; the game logic advances one frame.
- `serve`, out, 1: one-cycle pulse; the game logic recentres the ball and launches it.
- `serve_dir`, out, 1: launch direction, 0 = toward left, 1 = toward right. Valid whenever `serve` is high.
- `score_left`, out, 4: left player's score.
- `score_right`, out, 4: right player's score.
- `winner`, out, 2: 00 = none, 01 = left, 10 = right.
- `state`, out, 3: current state encoding, for LEDs.

## Operation
States:
- **IDLE**
  - Rising edge of `start` → SERVE, with the frame counter cleared.
  - `serve_dir` latched from `random[0]`.
- **SERVE**
  - Counts `frame_tick` while `pause` is low.
  - When the count reaches `SERVE_DELAY`: `serve` pulses and the state goes to PLAY.
- **PLAY**
  - Each `frame_tick` with `pause` low → `step` pulse.
  - `miss_left` alone: `score_right` +1, `serve_dir` ← 0 (serve toward the player who lost the point), → POINT.
  - `miss_right` alone: mirror of `miss_left` (`score_left` +1, `serve_dir` ← 1).
  - Both misses in the same cycle: draw. No score change, `serve_dir` ← `random[0]`, → POINT.
  - A miss has priority over `frame_tick` in the same cycle: no `step` is issued.
- **POINT**
  - Counts `frame_tick` while `pause` is low. At `POINT_HOLD`:
    - If either score equals `WIN_SCORE`: `winner` is set, → OVER.
    - Otherwise → SERVE.
- **OVER**
  - Rising edge of `start`: both scores cleared, `winner` ← 00, `serve_dir` ← `random[0]`, → SERVE.

Rules:
- `start` edge detect: the registered previous value is compared with the current one. A `start` held high through reset does not trigger a start.
- Misses are ignored outside PLAY.
- Scores never exceed `WIN_SCORE`. The increment and the win check use the post-increment value.
- `pause` has no effect in IDLE or OVER. It freezes the frame counter in SERVE and POINT; counting resumes from the held value.
- `step` and `serve` are never high in the same cycle.

## Timing
- Reset values: state IDLE, scores 0, `winner` 00, `serve_dir` 0, `step` 0, `serve` 0, frame counter 0, start-edge register 1.
- All outputs are registered.
- `step` is high exactly 1 cycle after the `frame_tick` cycle.
- `serve` is high 1 cycle after the final counting `frame_tick`. The state reads PLAY in that same cycle.
- Scores and state update 1 cycle after the miss pulse.
- Reset mid-operation: everything returns to the reset values on the next edge. No pulse is emitted in that cycle.

## Structure
- Shared package `pong_pkg`:
  - state enum (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4);
  - score width constant (4);
  - `winner` encodings.
- Sub-module `frame_timer`:
  - parameterised terminal count;
  - inputs: `clear`, `enable` (`frame_tick` & ~`pause`);
  - output: `done` pulse.
  - Instantiated once and shared between SERVE and POINT, with the terminal count muxed by state.

## Test plan
- Reset then `start` edge; with `SERVE_DELAY`=3, send 3 ticks → `serve` 1 cycle after the third tick, state PLAY, `serve_dir`=`random[0]`.
- PLAY: 5 ticks with `pause` toggling high on ticks 2–3 → exactly 3 `step` pulses, each 1 cycle after its tick.
- `miss_left` and `frame_tick` in the same cycle → no `step`, `score_right`=1, state POINT. After `POINT_HOLD` ticks: SERVE, `serve_dir`=0.
- `miss_left` and `miss_right` together → scores unchanged, state POINT.
- `WIN_SCORE`=2, two `miss_right` events → `score_left`=2, `winner`=01, state OVER. Further misses are ignored; `start` clears the scores.
- `rst` asserted during POINT with a partial count → state IDLE, scores 0. `start` held high through reset does not start the match.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer and its displays.
package pong_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // Increment that holds at the limit so a score can never pass the winning value.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter with a runtime terminal count; pulses done on the enabled tick that
// reaches the terminal count and wraps to zero in the same cycle.
module frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_inc == terminal) begin
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/match_controller.sv
// Match sequencer: gates per-frame game steps, issues serves, keeps score and
// declares the winner. All outputs come straight from flops.
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_HOLD  = 90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               miss_left,
    input  logic               miss_right,
    input  logic               start,
    input  logic               pause,
    input  logic [7:0]         random,
    output logic               step,
    output logic               serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int HOLD_MAX = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]   SERVE_TC = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   POINT_TC = CNT_W'(POINT_HOLD);
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               step_q, step_d;
    logic               serve_q, serve_d;
    logic               start_prev_q, start_prev_d;

    logic               start_rise;
    logic               tick_en;
    logic               timer_clear;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_tc;
    logic               unused_rnd;

    assign unused_rnd  = ^random[7:1];
    assign start_rise  = start & ~start_prev_q;
    assign tick_en     = frame_tick & ~pause;
    // One timer serves both waiting states; it sits cleared everywhere else so each
    // SERVE/POINT visit starts counting from zero.
    assign timer_clear = (state_q != ST_SERVE) && (state_q != ST_POINT);
    assign timer_tc    = (state_q == ST_POINT) ? POINT_TC : SERVE_TC;

    frame_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (tick_en),
        .terminal(timer_tc),
        .done    (timer_done)
    );

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        serve_dir_d   = serve_dir_q;
        step_d        = 1'b0;
        serve_d       = 1'b0;
        start_prev_d  = start;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    serve_dir_d = random[0];
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (timer_done) begin
                    serve_d = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A miss wins over a same-cycle frame tick: no step for that frame.
                if (miss_left && miss_right) begin
                    serve_dir_d = random[0];
                    state_d     = ST_POINT;
                end else if (miss_left) begin
                    score_right_d = sat_inc(score_right_q, WIN_VAL);
                    serve_dir_d   = 1'b0;
                    state_d       = ST_POINT;
                end else if (miss_right) begin
                    score_left_d = sat_inc(score_left_q, WIN_VAL);
                    serve_dir_d  = 1'b1;
                    state_d      = ST_POINT;
                end else if (tick_en) begin
                    step_d = 1'b1;
                end
            end
            ST_POINT: begin
                if (timer_done) begin
                    if (score_left_q == WIN_VAL) begin
                        winner_d = WIN_LEFT;
                        state_d  = ST_OVER;
                    end else if (score_right_q == WIN_VAL) begin
                        winner_d = WIN_RIGHT;
                        state_d  = ST_OVER;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    winner_d      = WIN_NONE;
                    serve_dir_d   = random[0];
                    state_d       = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // start_prev resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            winner_q      <= WIN_NONE;
            serve_dir_q   <= 1'b0;
            step_q        <= 1'b0;
            serve_q       <= 1'b0;
            start_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            serve_dir_q   <= serve_dir_d;
            step_q        <= step_d;
            serve_q       <= serve_d;
            start_prev_q  <= start_prev_d;
        end
    end

    assign step        = step_q;
    assign serve       = serve_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: a per-cycle vector table for the match flow
// plus hand-written reset sequences.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst, frame_tick, miss_left, miss_right, start, pause;
    logic [7:0] random;
    logic       step, serve, serve_dir;
    logic [3:0] score_left, score_right;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_controller #(
        .WIN_SCORE  (2),
        .SERVE_DELAY(3),
        .POINT_HOLD (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .start      (start),
        .pause      (pause),
        .random     (random),
        .step       (step),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .winner     (winner),
        .state      (state)
    );

    typedef struct {
        logic       ft, ml, mr, st, pa;
        logic [7:0] rnd;
        logic       e_step, e_serve, e_dir;
        logic [3:0] e_sl, e_sr;
        logic [1:0] e_win;
        logic [2:0] e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int ft, ml, mr, st, pa, rnd,
                                input int stp, srv, dir, sl, sr, win, s);
        vec_t v;
        v.ft = 1'(ft); v.ml = 1'(ml); v.mr = 1'(mr); v.st = 1'(st); v.pa = 1'(pa);
        v.rnd = 8'(rnd);
        v.e_step = 1'(stp); v.e_serve = 1'(srv); v.e_dir = 1'(dir);
        v.e_sl = 4'(sl); v.e_sr = 4'(sr); v.e_win = 2'(win); v.e_state = 3'(s);
        return v;
    endfunction

    task automatic drive(input logic r, ft, ml, mr, st, pa, input logic [7:0] rnd);
        @(negedge clk);
        rst = r; frame_tick = ft; miss_left = ml; miss_right = mr;
        start = st; pause = pa; random = rnd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic stp, srv, dir,
                         input logic [3:0] sl, sr, input logic [1:0] win, input logic [2:0] s);
        logic [15:0] act, exp;
        act = {step, serve, serve_dir, score_left, score_right, winner, state};
        exp = {stp, srv, dir, sl, sr, win, s};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got step=%b serve=%b dir=%b sl=%0d sr=%0d win=%b state=%0d, want step=%b serve=%b dir=%b sl=%0d sr=%0d win=%b state=%0d",
                     name, step, serve, serve_dir, score_left, score_right, winner, state,
                     stp, srv, dir, sl, sr, win, s);
        end
    endtask

    initial begin
        //                ft ml mr st pa rnd   stp srv dir sl sr win state
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,    0,  0,  0,  0, 0, 0,  0)); // start held from reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0,  0,  0,  0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,    0,  0,  1,  0, 0, 0,  1)); // edge -> SERVE
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  0, 0, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,    0,  0,  1,  0, 0, 0,  1)); // paused tick
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  0, 0, 0,  1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0,  0,  1,  0, 0, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  1,  1,  0, 0, 0,  2)); // serve, PLAY
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0,  0,  1,  0, 0, 0,  2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1,  0,  1,  0, 0, 0,  2)); // 5 ticks, 2-3 paused
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,    0,  0,  1,  0, 0, 0,  2));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,    0,  0,  1,  0, 0, 0,  2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1,  0,  1,  0, 0, 0,  2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1,  0,  1,  0, 0, 0,  2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0,  0,  1,  0, 0, 0,  2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    0,  0,  0,  0, 1, 0,  3)); // miss_left + tick
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,    0,  0,  0,  0, 1, 0,  3)); // miss ignored
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  0,  0, 1, 0,  3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  0,  0, 1, 0,  1)); // back to SERVE
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  0,  0, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  0,  0, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  1,  0,  0, 1, 0,  2));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1,    0,  0,  1,  0, 1, 0,  3)); // draw
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  0, 1, 0,  3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  0, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  0, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  0, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  1,  1,  0, 1, 0,  2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,    0,  0,  1,  1, 1, 0,  3)); // miss_right
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  1, 1, 0,  3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  1, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  1, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  1, 1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  1,  1,  1, 1, 0,  2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,    0,  0,  1,  2, 1, 0,  3)); // left reaches 2
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  2, 1, 0,  3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    0,  0,  1,  2, 1, 1,  4)); // OVER, left wins
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,    0,  0,  1,  2, 1, 1,  4));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0,  0,  1,  2, 1, 1,  4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0,  0,  1,  2, 1, 1,  4));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,    0,  0,  0,  0, 0, 0,  1)); // restart clears
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,  0,  0,  0, 0, 0,  1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,  0,  0,  0, 0, 0,  1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,  1,  0,  0, 0, 0,  2));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,    0,  0,  1,  1, 0, 0,  3));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,  0,  1,  1, 0, 0,  3)); // partial POINT count

        rst = 1'b1; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        start = 1'b1; pause = 1'b0; random = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].ft, vecs[i].ml, vecs[i].mr, vecs[i].st, vecs[i].pa, vecs[i].rnd);
            check($sformatf("vec%0d", i), vecs[i].e_step, vecs[i].e_serve, vecs[i].e_dir,
                  vecs[i].e_sl, vecs[i].e_sr, vecs[i].e_win, vecs[i].e_state);
        end

        // Reset during POINT with start held high, then start stays high after release.
        drive(1'b1, 1, 0, 0, 1, 0, 8'h01);
        check("rst_in_point", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1, 0, 0, 1, 0, 8'h01);
            check($sformatf("start_held%0d", k), 0, 0, 0, 0, 0, 0, 0);
        end
        drive(1'b0, 0, 0, 0, 0, 0, 8'h01);
        check("start_low", 0, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 0, 0, 0, 1, 0, 8'hFF);
        check("start_edge", 0, 0, 1, 0, 0, 0, 1);
        drive(1'b0, 1, 0, 0, 1, 0, 8'h00);
        drive(1'b0, 1, 0, 0, 1, 0, 8'h00);
        drive(1'b0, 1, 0, 0, 1, 0, 8'h00);
        check("serve_again", 0, 1, 1, 0, 0, 0, 2);

        // Reset on a cycle that would otherwise produce a step: no pulse comes out.
        drive(1'b1, 1, 0, 0, 0, 0, 8'h00);
        check("rst_no_step", 0, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 1, 0, 0, 0, 0, 8'h00);
        check("idle_after_rst", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
